// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to two functional-unit results per cycle in
// rotating priority order and broadcasts them on the CDB one cycle later.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int XLEN    = 32,
    parameter int CDB_W   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     squash,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic [NUM_REQ*XLEN-1:0]  req_value,
    input  logic [NUM_REQ*XLEN-1:0]  req_npc,
    input  logic [NUM_REQ-1:0]       req_take_branch,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [CDB_W-1:0]         cdb_valid,
    output logic [CDB_W*TAG_W-1:0]   cdb_tag,
    output logic [CDB_W*XLEN-1:0]    cdb_value,
    output logic [CDB_W*XLEN-1:0]    cdb_npc,
    output logic [CDB_W-1:0]         cdb_take_branch
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [CDB_W-1:0]       cdb_valid_q, cdb_valid_d;
    logic [CDB_W*TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [CDB_W*XLEN-1:0]  cdb_value_q, cdb_value_d;
    logic [CDB_W*XLEN-1:0]  cdb_npc_q, cdb_npc_d;
    logic [CDB_W-1:0]       cdb_tb_q, cdb_tb_d;

    logic [TAG_W-1:0] tag_a   [NUM_REQ];
    logic [XLEN-1:0]  value_a [NUM_REQ];
    logic [XLEN-1:0]  npc_a   [NUM_REQ];

    logic             first_found, second_found;
    logic [PTR_W-1:0] first_idx, second_idx;
    logic             grant_en;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_a[i]   = req_tag[i*TAG_W +: TAG_W];
            value_a[i] = req_value[i*XLEN +: XLEN];
            npc_a[i]   = req_npc[i*XLEN +: XLEN];
        end
    end

    // Scan from rr_ptr with wraparound; the first two valid requesters win the slots.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        sum          = '0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[PTR_W-1:0];
            if (req_valid[idx]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = idx;
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = idx;
                end
            end
        end
    end

    assign grant_en = enable && !squash && !reset;

    always_comb begin
        req_ready = '0;
        if (grant_en) begin
            if (first_found) begin
                req_ready[first_idx] = 1'b1;
            end
            if (second_found) begin
                req_ready[second_idx] = 1'b1;
            end
        end
    end

    // Unused slots carry all-zero fields so downstream never sees stale data.
    always_comb begin
        logic [PTR_W-1:0] last_idx;
        logic [PTR_W:0]   nxt;
        cdb_valid_d = '0;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
        cdb_npc_d   = '0;
        cdb_tb_d    = '0;
        if (first_found) begin
            cdb_valid_d[0]         = 1'b1;
            cdb_tag_d[0 +: TAG_W]  = tag_a[first_idx];
            cdb_value_d[0 +: XLEN] = value_a[first_idx];
            cdb_npc_d[0 +: XLEN]   = npc_a[first_idx];
            cdb_tb_d[0]            = req_take_branch[first_idx];
        end
        if (second_found) begin
            cdb_valid_d[1]             = 1'b1;
            cdb_tag_d[TAG_W +: TAG_W]  = tag_a[second_idx];
            cdb_value_d[XLEN +: XLEN]  = value_a[second_idx];
            cdb_npc_d[XLEN +: XLEN]    = npc_a[second_idx];
            cdb_tb_d[1]                = req_take_branch[second_idx];
        end

        last_idx = second_found ? second_idx : first_idx;
        nxt      = {1'b0, last_idx} + (PTR_W+1)'(1);
        if (nxt >= NUM_REQ_W) begin
            nxt = '0;
        end
        rr_ptr_d = first_found ? nxt[PTR_W-1:0] : rr_ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_npc_q   <= '0;
            cdb_tb_q    <= '0;
        end else if (squash) begin
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_npc_q   <= '0;
            cdb_tb_q    <= '0;
        end else if (enable) begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_npc_q   <= cdb_npc_d;
            cdb_tb_q    <= cdb_tb_d;
        end
    end

    assign cdb_valid       = cdb_valid_q;
    assign cdb_tag         = cdb_tag_q;
    assign cdb_value       = cdb_value_q;
    assign cdb_npc         = cdb_npc_q;
    assign cdb_take_branch = cdb_tb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int XL = 32;
    localparam int CW = 2;

    logic clock = 1'b0;
    logic reset, enable, squash;
    logic [N-1:0]    req_valid, req_take_branch, req_ready;
    logic [N*TW-1:0] req_tag;
    logic [N*XL-1:0] req_value, req_npc;
    logic [CW-1:0]    cdb_valid, cdb_take_branch;
    logic [CW*TW-1:0] cdb_tag;
    logic [CW*XL-1:0] cdb_value, cdb_npc;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .XLEN(XL), .CDB_W(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .squash(squash),
        .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
        .req_npc(req_npc), .req_take_branch(req_take_branch), .req_ready(req_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_npc(cdb_npc), .cdb_take_branch(cdb_take_branch)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    int          m_rr;
    logic        m_v   [CW];
    logic [TW-1:0] m_tag [CW];
    logic [XL-1:0] m_val [CW];
    logic [XL-1:0] m_npc [CW];
    logic        m_tb  [CW];
    int          g[2];
    int          ng;
    logic [N-1:0] m_ready;

    task automatic model_clear();
        for (int s = 0; s < CW; s++) begin
            m_v[s] = 0; m_tag[s] = 0; m_val[s] = 0; m_npc[s] = 0; m_tb[s] = 0;
        end
    endtask

    task automatic compute();
        int q[$];
        q = {};
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (req_valid[idx]) q.push_back(idx);
        end
        ng = (q.size() > 2) ? 2 : q.size();
        g[0] = (ng > 0) ? q[0] : -1;
        g[1] = (ng > 1) ? q[1] : -1;
        m_ready = '0;
        if (!reset && !squash && enable)
            for (int s = 0; s < ng; s++) m_ready[g[s]] = 1'b1;
    endtask

    task automatic model_clock();
        if (reset) begin
            model_clear();
            m_rr = 0;
        end else if (squash) begin
            model_clear();
        end else if (enable) begin
            model_clear();
            for (int s = 0; s < ng; s++) begin
                m_v[s]   = 1'b1;
                m_tag[s] = req_tag[g[s]*TW +: TW];
                m_val[s] = req_value[g[s]*XL +: XL];
                m_npc[s] = req_npc[g[s]*XL +: XL];
                m_tb[s]  = req_take_branch[g[s]];
            end
            if (ng > 0) m_rr = (g[ng-1] + 1) % N;
        end
    endtask

    task automatic check_cdb_model();
        for (int s = 0; s < CW; s++) begin
            chk($sformatf("rnd_valid%0d", s), 64'(cdb_valid[s]), 64'(m_v[s]));
            chk($sformatf("rnd_tag%0d", s),   64'(cdb_tag[s*TW +: TW]), 64'(m_tag[s]));
            chk($sformatf("rnd_value%0d", s), 64'(cdb_value[s*XL +: XL]), 64'(m_val[s]));
            chk($sformatf("rnd_npc%0d", s),   64'(cdb_npc[s*XL +: XL]), 64'(m_npc[s]));
            chk($sformatf("rnd_tb%0d", s),    64'(cdb_take_branch[s]), 64'(m_tb[s]));
        end
    endtask

    // Directed-table fields are a fixed function of the requester index.
    task automatic set_fixed_fields();
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW]   = TW'(10 + i);
            req_value[i*XL +: XL] = 32'h1000_0000 + XL'(i);
            req_npc[i*XL +: XL]   = 32'h2000_0000 + XL'(i);
            req_take_branch[i]    = i[0];
        end
    endtask

    task automatic check_slot(input int s, input int idx);
        if (idx < 0) begin
            chk($sformatf("tbl_valid%0d", s), 64'(cdb_valid[s]), 64'd0);
            chk($sformatf("tbl_tag%0d", s),   64'(cdb_tag[s*TW +: TW]), 64'd0);
            chk($sformatf("tbl_value%0d", s), 64'(cdb_value[s*XL +: XL]), 64'd0);
            chk($sformatf("tbl_npc%0d", s),   64'(cdb_npc[s*XL +: XL]), 64'd0);
            chk($sformatf("tbl_tb%0d", s),    64'(cdb_take_branch[s]), 64'd0);
        end else begin
            chk($sformatf("tbl_valid%0d", s), 64'(cdb_valid[s]), 64'd1);
            chk($sformatf("tbl_tag%0d", s),   64'(cdb_tag[s*TW +: TW]), 64'(10 + idx));
            chk($sformatf("tbl_value%0d", s), 64'(cdb_value[s*XL +: XL]), 64'(32'h1000_0000 + idx));
            chk($sformatf("tbl_npc%0d", s),   64'(cdb_npc[s*XL +: XL]), 64'(32'h2000_0000 + idx));
            chk($sformatf("tbl_tb%0d", s),    64'(cdb_take_branch[s]), 64'(idx % 2));
        end
    endtask

    // One cycle: inputs already driven; ready checked mid-cycle, CDB after the edge.
    task automatic step_model();
        compute();
        @(negedge clock);
        chk("rnd_ready", 64'(req_ready), 64'(m_ready));
        @(posedge clock);
        model_clock();
        #1;
        check_cdb_model();
    endtask

    task automatic do_reset();
        reset = 1; enable = 1; squash = 0; req_valid = '0;
        compute();
        @(posedge clock);
        model_clock();
        #1;
        reset = 0;
    endtask

    typedef struct {
        logic       rst, en, sq;
        logic [3:0] valid;
        logic [3:0] ready;
        int         s0, s1;
    } vec_t;

    vec_t tbl[$];

    int cnt[N];
    int last_g[N];

    initial begin
        reset = 1; enable = 0; squash = 0;
        req_valid = '0; req_tag = '0; req_value = '0; req_npc = '0; req_take_branch = '0;
        m_rr = 0;
        model_clear();

        // rst en sq valid ready slot0 slot1
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'hF, 4'h0, -1, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hF, 4'h3,  0,  1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hA, 4'hA,  3,  1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hF, 4'hC,  2,  3});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hA, 4'hA,  1,  3});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h8, 4'h8,  3, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, -1, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h4, 4'h4,  2, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hF, 4'h9,  3,  0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'hF, 4'h0,  3,  0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'hF, 4'h0,  3,  0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 4'hF, 4'h0,  3,  0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hF, 4'h6,  1,  2});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'hF, 4'h0, -1, -1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4'hF, 4'h0, -1, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h1, 4'h1,  0, -1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 4'hF, 4'h0, -1, -1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'hF, 4'h3,  0,  1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, -1, -1});

        set_fixed_fields();
        foreach (tbl[i]) begin
            reset = tbl[i].rst; enable = tbl[i].en; squash = tbl[i].sq;
            req_valid = tbl[i].valid;
            compute();
            @(negedge clock);
            chk($sformatf("tbl_ready[%0d]", i), 64'(req_ready), 64'(tbl[i].ready));
            @(posedge clock);
            model_clock();
            #1;
            check_slot(0, tbl[i].s0);
            check_slot(1, tbl[i].s1);
        end

        // Lone high-index requester with pointer at 0.
        do_reset();
        set_fixed_fields();
        req_tag[3*TW +: TW]   = 5'd7;
        req_value[3*XL +: XL] = 32'hDEAD_BEEF;
        req_valid = 4'b1000;
        @(negedge clock);
        chk("solo_ready", 64'(req_ready), 64'h8);
        @(posedge clock);
        #1;
        chk("solo_valid", 64'(cdb_valid), 64'h1);
        chk("solo_tag",   64'(cdb_tag[0 +: TW]), 64'd7);
        chk("solo_value", 64'(cdb_value[0 +: XL]), 64'hDEAD_BEEF);
        chk("solo_slot1", 64'({cdb_tag[TW +: TW], cdb_value[XL +: XL]}), 64'd0);
        req_valid = 4'hF;
        @(negedge clock);
        chk("solo_ptr_after", 64'(req_ready), 64'h3);
        @(posedge clock);
        #1;

        // Fairness: all requesters held valid for 20 cycles.
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) begin cnt[i] = 0; last_g[i] = -1; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    chk($sformatf("fair_gap%0d", i), 64'(c - last_g[i] <= 2), 64'd1);
                    cnt[i]++;
                    last_g[i] = c;
                end
            end
            @(posedge clock);
            #1;
        end
        for (int i = 0; i < N; i++) chk($sformatf("fair_count%0d", i), 64'(cnt[i]), 64'd10);

        // Randomized traffic against the reference model.
        do_reset();
        m_rr = 0;
        model_clear();
        for (int c = 0; c < 400; c++) begin
            reset  = ($urandom_range(0, 39) == 0);
            squash = ($urandom_range(0, 14) == 0);
            enable = ($urandom_range(0, 4) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_tag[i*TW +: TW]   = TW'($urandom);
                req_value[i*XL +: XL] = $urandom;
                req_npc[i*XL +: XL]   = $urandom;
                req_take_branch[i]    = 1'($urandom);
            end
            step_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
